// File: rtl/morphle_pkg.sv
// Shared Morphle definitions: ycell configuration codes, loader FSM states
// and a bit-select helper used when serialising codes MSB first.
package morphle_pkg;

    localparam int CONF_BITS = 3;

    localparam logic [CONF_BITS-1:0] CODE_SPACE = 3'b000;
    localparam logic [CONF_BITS-1:0] CODE_PLUS  = 3'b001;
    localparam logic [CONF_BITS-1:0] CODE_MINUS = 3'b010;
    localparam logic [CONF_BITS-1:0] CODE_VBAR  = 3'b011;
    localparam logic [CONF_BITS-1:0] CODE_ONE   = 3'b100;
    localparam logic [CONF_BITS-1:0] CODE_ZERO  = 3'b101;
    localparam logic [CONF_BITS-1:0] CODE_Y     = 3'b110;
    localparam logic [CONF_BITS-1:0] CODE_N     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_HOLD  = 2'd3
    } ld_state_e;

    function automatic logic code_bit(input logic [CONF_BITS-1:0] c, input logic [1:0] idx);
        case (idx)
            2'd0:    return c[0];
            2'd1:    return c[1];
            default: return c[2];
        endcase
    endfunction

endpackage

// File: rtl/ycconfig_phase_timer.sv
// Phase down-counter: load sets the count, expired is high while it reads zero.
// A load of N keeps expired low for N cycles; no backpressure.
module ycconfig_phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expired
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign expired = (cnt == 8'd0);

endmodule

// File: rtl/ycconfig_loader.sv
// Serialises 3-bit ycell codes onto a ycconfig chain: 1 + 3*(2*DIV+1) cycles per code.
// code_ready only in IDLE; optional clear sequence under YCCONFIG_LOADER_CLEAR_EN.
module ycconfig_loader
    import morphle_pkg::*;
#(
    parameter int CHAIN_CELLS = 16,
    parameter int DIV         = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [CONF_BITS-1:0]             code,
    input  logic                             code_valid,
`ifdef YCCONFIG_LOADER_CLEAR_EN
    input  logic                             clear,
`endif
    output logic                             code_ready,
    output logic                             confclk,
    output logic                             cbitout,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(CHAIN_CELLS+1)-1:0] cell_cnt
);

    localparam int              CW       = $clog2(CHAIN_CELLS+1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(CHAIN_CELLS - 1);
    localparam logic [7:0]      DIV_M1   = 8'(DIV - 1);
    localparam logic [1:0]      TOP_IDX  = 2'(CONF_BITS - 1);

    ld_state_e            state, state_nxt;
    logic [CONF_BITS-1:0] code_q;
    logic [1:0]           idx;
    logic                 expired;
    logic                 tmr_load;
    logic [7:0]           tmr_val;
    logic                 accept;
    logic                 last_bit;
    logic                 clr_start, clr_more, clr_last;

`ifdef YCCONFIG_LOADER_CLEAR_EN
    logic          clearing;
    logic [CW-1:0] clr_left;

    assign clr_start = (state == ST_IDLE) && clear;
    assign clr_more  = clearing && (clr_left != '0);
    assign clr_last  = clearing && (clr_left == '0);

    // clr_left counts the space codes still to go after the current one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clearing <= 1'b0;
            clr_left <= '0;
        end else if (clr_start) begin
            clearing <= 1'b1;
            clr_left <= LAST_CNT;
        end else if (clearing && last_bit) begin
            if (clr_left != '0) begin
                clr_left <= clr_left - 1'b1;
            end else begin
                clearing <= 1'b0;
            end
        end
    end
`else
    assign clr_start = 1'b0;
    assign clr_more  = 1'b0;
    assign clr_last  = 1'b0;
`endif

    assign accept   = (state == ST_IDLE) && code_valid && !clr_start;
    assign last_bit = (state == ST_HOLD) && (idx == 2'd0);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (clr_start || accept) state_nxt = ST_SETUP;
            ST_SETUP: if (expired) state_nxt = ST_HIGH;
            ST_HIGH:  if (expired) state_nxt = ST_HOLD;
            ST_HOLD:  state_nxt = (idx != 2'd0 || clr_more) ? ST_SETUP : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Every state entry restarts the phase; HOLD is a single cycle
    assign tmr_load = (state_nxt != state);
    assign tmr_val  = (state_nxt == ST_HOLD) ? 8'd0 : DIV_M1;

    ycconfig_phase_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            code_q  <= CODE_SPACE;
            idx     <= 2'd0;
            confclk <= 1'b0;
            cbitout <= 1'b0;
        end else begin
            state   <= state_nxt;
            confclk <= (state_nxt == ST_HIGH);
            if (clr_start) begin
                code_q  <= CODE_SPACE;
                idx     <= TOP_IDX;
                cbitout <= code_bit(CODE_SPACE, TOP_IDX);
            end else if (accept) begin
                code_q  <= code;
                idx     <= TOP_IDX;
                cbitout <= code_bit(code, TOP_IDX);
            end else if (state == ST_HOLD) begin
                if (idx != 2'd0) begin
                    idx     <= idx - 2'd1;
                    cbitout <= code_bit(code_q, idx - 2'd1);
                end else if (clr_more) begin
                    idx     <= TOP_IDX;
                    cbitout <= code_bit(code_q, TOP_IDX);
                end
            end
        end
    end

    // done is registered so it coincides with the wrapped cell_cnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_cnt <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (last_bit && !clr_more) begin
                if (clr_last || cell_cnt == LAST_CNT) begin
                    cell_cnt <= '0;
                    done     <= 1'b1;
                end else begin
                    cell_cnt <= cell_cnt + 1'b1;
                end
            end
        end
    end

    assign code_ready = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_ycconfig_loader.sv
// Loader driving two behavioural ycconfig cells; scoreboard of strobe bits and code completions.
module tb_ycconfig_loader;
    import morphle_pkg::*;

    localparam int CHAIN = 4;
    localparam int DIVP  = 2;
    localparam int CW    = $clog2(CHAIN+1);
    localparam int CODE_CYC = 3*(2*DIVP+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    code = 3'b000;
    logic          code_valid = 1'b0;
    logic          clear = 1'b0;
    logic          code_ready, confclk, cbitout, busy, done;
    logic [CW-1:0] cell_cnt;

    always #5 clk = ~clk;

    ycconfig_loader #(.CHAIN_CELLS(CHAIN), .DIV(DIVP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code       (code),
        .code_valid (code_valid),
`ifdef YCCONFIG_LOADER_CLEAR_EN
        .clear      (clear),
`endif
        .code_ready (code_ready),
        .confclk    (confclk),
        .cbitout    (cbitout),
        .busy       (busy),
        .done       (done),
        .cell_cnt   (cell_cnt)
    );

    // Two ycconfig cells: shift MSB-first on confclk rise, head cell nearest the loader
    logic [2:0] cell0 = 3'b000;
    logic [2:0] cell1 = 3'b000;
    always @(posedge confclk) begin
        cell0 <= {cell0[1:0], cbitout};
        cell1 <= {cell1[1:0], cell0[2]};
    end

    function automatic int match0(input logic [2:0] c);
        return (c == CODE_ZERO) ? 1 : 0;
    endfunction

    function automatic int is_empty(input logic [2:0] c);
        return (c == CODE_SPACE) ? 1 : 0;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    typedef struct {
        int low;
        int cnt;
        int dn;
    } cmp_t;

    logic exp_bits[$];
    cmp_t exp_cmp[$];

    int   rises = 0;
    int   done_seen = 0;
    int   low_run = 0;
    logic conf_prev = 1'b0;
    logic rdy_prev = 1'b1;
    logic bit_at_rise = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            low_run = 0;
        end else begin
            if (confclk && !conf_prev) begin
                rises++;
                bit_at_rise = cbitout;
                if (exp_bits.size() == 0) begin
                    check("strobe_unexpected", 1, 0);
                end else begin
                    check("strobe_bit", int'(cbitout), int'(exp_bits.pop_front()));
                end
            end
            if (!confclk && conf_prev)
                check("bit_hold", int'(cbitout), int'(bit_at_rise));
            if (done) done_seen++;
            if (!code_ready) begin
                low_run++;
            end else if (!rdy_prev) begin
                if (exp_cmp.size() == 0) begin
                    check("completion_unexpected", 1, 0);
                end else begin
                    cmp_t e;
                    e = exp_cmp.pop_front();
                    check("ready_low_cycles", low_run, e.low);
                    check("cell_cnt", int'(cell_cnt), e.cnt);
                    check("done_at_wrap", int'(done), e.dn);
                end
                low_run = 0;
            end
        end
        conf_prev = confclk;
        rdy_prev  = code_ready;
    end

    task automatic send(input logic [2:0] c, input int ecnt, input int edone, input bit keep_valid);
        int n;
        cmp_t e;
        n = 0;
        while (!code_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) timeout("ready_wait");
        exp_bits.push_back(c[2]);
        exp_bits.push_back(c[1]);
        exp_bits.push_back(c[0]);
        e.low = CODE_CYC; e.cnt = ecnt; e.dn = edone;
        exp_cmp.push_back(e);
        code = c;
        code_valid = 1'b1;
        @(posedge clk); #1;
        if (!keep_valid) code_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_cmp.size() != 0 || exp_bits.size() != 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) timeout("drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d0, n;

        // Reset values while held in reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_confclk", int'(confclk), 0);
        check("rst_cbitout", int'(cbitout), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cell_cnt", int'(cell_cnt), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", int'(code_ready), 1);

        // Idle: no strobes over 50 cycles
        r0 = rises;
        repeat (50) @(posedge clk);
        #1;
        check("idle_no_strobes", rises - r0, 0);
        check("idle_confclk", int'(confclk), 0);

        // Single "0" code: bits 1,0,1
        r0 = rises;
        send(CODE_ZERO, 1, 0, 1'b0);
        drain();
        check("zero_strobes", rises - r0, 3);
        check("cell0_code", int'(cell0), int'(CODE_ZERO));
        check("cell0_hmatch0", match0(cell0), 1);
        check("cell0_vmatch0", match0(cell0), 1);

        // "+" then "|" back-to-back with valid held
        r0 = rises;
        send(CODE_PLUS, 2, 0, 1'b1);
        send(CODE_VBAR, 3, 0, 1'b0);
        drain();
        check("b2b_strobes", rises - r0, 6);
        check("b2b_cell1", int'(cell1), int'(CODE_PLUS));
        check("b2b_cell0", int'(cell0), int'(CODE_VBAR));

        // Fourth code wraps the count
        d0 = done_seen;
        send(CODE_Y, 0, 1, 1'b0);
        drain();
        check("wrap_done_pulses", done_seen - d0, 1);
        check("wrap_cell0", int'(cell0), int'(CODE_Y));
        check("wrap_cell1", int'(cell1), int'(CODE_VBAR));

        // Reset during HIGH of bit 1 of "-" (bit 1 is a one)
        exp_bits.push_back(1'b0);
        exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b0);
        r0 = rises;
        code = CODE_MINUS;
        code_valid = 1'b1;
        @(posedge clk); #1;
        code_valid = 1'b0;
        n = 0;
        while (rises - r0 < 2 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 100) timeout("strobe_wait");
        check("pre_rst_confclk", int'(confclk), 1);
        check("pre_rst_cbitout", int'(cbitout), 1);
        rst_n = 1'b0;
        #1;
        check("abort_confclk", int'(confclk), 0);
        check("abort_cbitout", int'(cbitout), 0);
        check("abort_cell_cnt", int'(cell_cnt), 0);
        exp_bits.delete();
        exp_cmp.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("release_ready", int'(code_ready), 1);
        check("release_cell_cnt", int'(cell_cnt), 0);
        check("release_busy", int'(busy), 0);

`ifdef YCCONFIG_LOADER_CLEAR_EN
        // Load Y,N then clear the whole chain with space codes
        send(CODE_Y, 1, 0, 1'b0);
        send(CODE_N, 2, 0, 1'b0);
        drain();
        check("pre_clear_cell0", int'(cell0), int'(CODE_N));
        check("pre_clear_cell1", int'(cell1), int'(CODE_Y));
        begin
            cmp_t e;
            for (int i = 0; i < 3*CHAIN; i++) exp_bits.push_back(1'b0);
            e.low = CHAIN*CODE_CYC; e.cnt = 0; e.dn = 1;
            exp_cmp.push_back(e);
        end
        r0 = rises;
        d0 = done_seen;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear_busy", int'(busy), 1);
        drain();
        check("clear_strobes", rises - r0, 3*CHAIN);
        check("clear_done_pulses", done_seen - d0, 1);
        check("clear_cell0_empty", is_empty(cell0), 1);
        check("clear_cell1_empty", is_empty(cell1), 1);
`endif

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
